// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubble injection.
// Optional bubble counter output enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic [31:0]       instr_id,
    input  logic [DATA_W-1:0] pc4_id,
    input  logic [DATA_W-1:0] rd1_id,
    input  logic [DATA_W-1:0] rd2_id,
    input  logic [DATA_W-1:0] imm_id,
    input  logic              flush,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [31:0]       instr_ex,
    output logic [DATA_W-1:0] pc4_ex,
    output logic [DATA_W-1:0] rd1_ex,
    output logic [DATA_W-1:0] rd2_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic              stall_if
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [15:0]       bubble_cnt
`endif
);

    // Control bundle is LSB-aligned: RegDest is bit 0, MemRead bit 3.
    localparam int MEMREAD = 3;

    typedef enum logic {RUN, STALL} state_t;

    state_t            state_q;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;

    logic [5:0] opcode;
    logic [4:0] rs, rt, rt_ex;
    logic       rs_used, rt_used;
    logic       hazard, bubble;

    assign opcode = instr_id[31:26];
    assign rs     = instr_id[25:21];
    assign rt     = instr_id[20:16];
    assign rt_ex  = instr_q[20:16];

    always_comb begin
        rt_used = 1'b0;
        rs_used = 1'b1;
        unique case (opcode)
            6'b000000, 6'b000100, 6'b000101,
            6'b101011, 6'b101001, 6'b101000: rt_used = 1'b1;
            6'b000010, 6'b000011, 6'b001111: rs_used = 1'b0;
            default: ;
        endcase
    end

    assign hazard = ctrl_q[MEMREAD] && (rt_ex != 5'd0) &&
                    ((rs_used && rs == rt_ex) ||
                     (rt_used && rt == rt_ex));

    assign stall_if = !reset && !flush &&
                      (state_q == RUN) && hazard;
    assign bubble   = !reset && (flush || stall_if);

    // Bubbles clear only control and instruction; datapath regs hold.
    always_comb begin
        ctrl_d  = ctrl_id;
        instr_d = instr_id;
        pc4_d   = pc4_id;
        rd1_d   = rd1_id;
        rd2_d   = rd2_id;
        imm_d   = imm_id;
        if (bubble) begin
            ctrl_d  = '0;
            instr_d = '0;
            pc4_d   = pc4_q;
            rd1_d   = rd1_q;
            rd2_d   = rd2_q;
            imm_d   = imm_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            ctrl_q  <= '0;
            instr_q <= '0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            unique case (state_q)
                RUN:     state_q <= stall_if ? STALL : RUN;
                STALL:   state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign ctrl_ex  = ctrl_q;
    assign instr_ex = instr_q;
    assign pc4_ex   = pc4_q;
    assign rd1_ex   = rd1_q;
    assign rd2_ex   = rd2_q;
    assign imm_ex   = imm_q;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (bubble && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign bubble_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage against a rule-level reference model.
// Bubble counter checks compile in when ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic [17:0] ctrl_id;
    logic [31:0] instr_id, pc4_id, rd1_id, rd2_id, imm_id;
    logic [17:0] ctrl_ex;
    logic [31:0] instr_ex, pc4_ex, rd1_ex, rd2_ex, imm_ex;
    logic        stall_if;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    id_ex_stage dut (
        .clk(clk), .reset(reset),
        .ctrl_id(ctrl_id), .instr_id(instr_id),
        .pc4_id(pc4_id), .rd1_id(rd1_id),
        .rd2_id(rd2_id), .imm_id(imm_id),
        .flush(flush),
        .ctrl_ex(ctrl_ex), .instr_ex(instr_ex),
        .pc4_ex(pc4_ex), .rd1_ex(rd1_ex),
        .rd2_ex(rd2_ex), .imm_ex(imm_ex),
        .stall_if(stall_if)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] c;
        logic [31:0] i, p, a, b, m;
        bit          dv;
        int          cnt;
    } ex_t;

    ex_t ex_q[$];
    bit  stall_q[$];
    int  checks = 0;
    int  errors = 0;

    // Model of what EX currently holds
    logic [17:0] m_ctrl;
    logic [31:0] m_instr, m_pc4, m_rd1, m_rd2, m_imm;
    bit          m_dv;
    int          m_cnt;
    bit          last_stall;

    localparam logic [17:0] C_LW   = 18'h0318;
    localparam logic [17:0] C_ADD  = 18'h0241;
    localparam logic [17:0] C_ADDI = 18'h0320;

    task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit m_hazard(logic [31:0] iid);
        logic [5:0] op = iid[31:26];
        logic [4:0] rs = iid[25:21];
        logic [4:0] rt = iid[20:16];
        logic [4:0] rx = m_instr[20:16];
        bit ru = !(op == 6'd2 || op == 6'd3 || op == 6'd15);
        bit tu;
        case (op)
            6'd0, 6'd4, 6'd5, 6'd43, 6'd41, 6'd40: tu = 1'b1;
            default: tu = 1'b0;
        endcase
        return m_ctrl[3] && rx != 5'd0 &&
               ((ru && rs == rx) || (tu && rt == rx));
    endfunction

    // Called just after a rising edge; ends just after the next one.
    task automatic step(bit r, bit f, logic [17:0] c,
                        logic [31:0] i, logic [31:0] p,
                        logic [31:0] a, logic [31:0] b,
                        logic [31:0] m);
        bit haz, st;
        ex_t e;
        #1;
        reset = r; flush = f; ctrl_id = c; instr_id = i;
        pc4_id = p; rd1_id = a; rd2_id = b; imm_id = m;
        haz = m_hazard(i);
        st  = !r && !f && haz;
        stall_q.push_back(st);
        last_stall = st;
        if (r) begin
            m_ctrl = '0; m_instr = '0; m_pc4 = '0;
            m_rd1 = '0; m_rd2 = '0; m_imm = '0;
            m_dv = 1; m_cnt = 0;
        end else if (f || haz) begin
            m_ctrl = '0; m_instr = '0; m_dv = 0;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_ctrl = c; m_instr = i; m_pc4 = p;
            m_rd1 = a; m_rd2 = b; m_imm = m;
            m_dv = 1;
        end
        e.c = m_ctrl; e.i = m_instr; e.p = m_pc4;
        e.a = m_rd1; e.b = m_rd2; e.m = m_imm;
        e.dv = m_dv; e.cnt = m_cnt;
        @(posedge clk);
        ex_q.push_back(e);
    endtask

    task automatic ins(bit f, logic [17:0] c, logic [31:0] i);
        step(0, f, c, i, $urandom, $urandom, $urandom, $urandom);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [11] = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd41,
                                 6'd40, 6'd2, 6'd3, 6'd15, 6'd35,
                                 6'd8};
        logic [5:0] op = ops[$urandom_range(0, 10)];
        logic [4:0] rs = 5'($urandom_range(0, 3));
        logic [4:0] rt = 5'($urandom_range(0, 3));
        logic [15:0] lo = 16'($urandom);
        return {op, rs, rt, lo};
    endfunction

    always begin
        @(negedge clk);
        if (stall_q.size() > 0)
            cmp("stall_if", 64'(stall_if), 64'(stall_q.pop_front()));
    end

    always begin
        ex_t e;
        @(posedge clk);
        #2;
        if (ex_q.size() > 0) begin
            e = ex_q.pop_front();
            cmp("ctrl_ex", 64'(ctrl_ex), 64'(e.c));
            cmp("instr_ex", 64'(instr_ex), 64'(e.i));
            if (e.dv) begin
                cmp("pc4_ex", 64'(pc4_ex), 64'(e.p));
                cmp("rd1_ex", 64'(rd1_ex), 64'(e.a));
                cmp("rd2_ex", 64'(rd2_ex), 64'(e.b));
                cmp("imm_ex", 64'(imm_ex), 64'(e.m));
            end
`ifdef ID_EX_BUBBLE_CNT_EN
            cmp("bubble_cnt", 64'(bubble_cnt), 64'(e.cnt));
`endif
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [17:0] rc;
        logic [31:0] ri;
        reset = 1; flush = 0; ctrl_id = '0; instr_id = '0;
        pc4_id = '0; rd1_id = '0; rd2_id = '0; imm_id = '0;
        m_ctrl = '0; m_instr = '0; m_dv = 0; m_cnt = 0;
        last_stall = 0;
        @(posedge clk);
        // Reset with random inputs, then one quiet cycle
        repeat (2)
            step(1, 1'($urandom), 18'($urandom), $urandom,
                 $urandom, $urandom, $urandom, $urandom);
        ins(0, '0, '0);

        // Load-use: add stalls one cycle and repeats
        ins(0, C_LW, {6'd35, 5'd9, 5'd8, 16'd0});
        ins(0, C_ADD, {6'd0, 5'd8, 5'd11, 5'd10, 11'h020});
        ins(0, C_ADD, {6'd0, 5'd8, 5'd11, 5'd10, 11'h020});
        ins(0, '0, '0);

        // Load then addi writing the loaded reg: no stall
        ins(0, C_LW, {6'd35, 5'd9, 5'd8, 16'd0});
        ins(0, C_ADDI, {6'd8, 5'd12, 5'd8, 16'd4});

        // Load to $0 never stalls
        ins(0, C_LW, {6'd35, 5'd9, 5'd0, 16'd0});
        ins(0, C_ADD, {6'd0, 5'd0, 5'd0, 5'd10, 11'h020});

        // Flush beats hazard; next instr is unstalled
        ins(0, C_LW, {6'd35, 5'd9, 5'd8, 16'd0});
        ins(1, C_ADD, {6'd0, 5'd8, 5'd11, 5'd10, 11'h020});
        ins(0, C_ADD, {6'd0, 5'd8, 5'd11, 5'd10, 11'h020});

        // Back-to-back dependent loads
        ins(0, C_LW, {6'd35, 5'd9, 5'd8, 16'd0});
        ins(0, C_LW, {6'd35, 5'd8, 5'd9, 16'd0});
        ins(0, C_LW, {6'd35, 5'd8, 5'd9, 16'd0});
        ins(0, C_ADD, {6'd0, 5'd9, 5'd9, 5'd10, 11'h020});
        ins(0, C_ADD, {6'd0, 5'd9, 5'd9, 5'd10, 11'h020});

        // Randomized traffic; hold ID while stalled
        rc = '0; ri = '0;
        for (int n = 0; n < 600; n++) begin
            if (!last_stall) begin
                rc = 18'($urandom);
                rc[3] = 1'($urandom_range(0, 1));
                ri = rand_instr();
            end
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) == 0,
                 rc, ri, $urandom, $urandom, $urandom, $urandom);
        end

`ifdef ID_EX_BUBBLE_CNT_EN
        step(1, 0, '0, '0, '0, '0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            ins(0, C_LW, {6'd35, 5'd9, 5'd8, 16'd0});
            ins(0, C_ADD, {6'd0, 5'd8, 5'd11, 5'd10, 11'h020});
            ins(0, C_ADD, {6'd0, 5'd8, 5'd11, 5'd10, 11'h020});
        end
        ins(1, C_ADD, '0);
        ins(1, C_ADD, '0);
        @(negedge clk);
        cmp("bubble_cnt_five", 64'(bubble_cnt), 64'd5);
        @(posedge clk);
        for (int k = 0; k < 65540; k++)
            ins(1, '0, '0);
        @(negedge clk);
        cmp("bubble_cnt_sat", 64'(bubble_cnt), 64'hFFFF);
        @(posedge clk);
`endif

        ins(0, '0, '0);
        repeat (3) @(posedge clk);
        #3;
        cmp("ex_q_drained", 64'(ex_q.size()), 64'd0);
        cmp("stall_q_drained", 64'(stall_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
